// File: rtl/bet_update_if.sv
// Erase-notification and shared BET RAM port bundle for bet_update.
// Latency: none; this bundle only groups signals.
// Backpressure: erase side is valid/ready; RAM side is req/gnt arbitration.
interface bet_update_if #(
    parameter int ADDR_W = 12
);
    logic              erase_valid;
    logic [ADDR_W-1:0] erase_addr;
    logic              erase_ready;
    logic              addr_err;
    logic              ram_req;
    logic              ram_gnt;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_w;
    logic              ram_w_en;
    logic              ram_r;

    // Flash controller / RAM arbiter side
    modport master (
        output erase_valid, erase_addr, ram_gnt, ram_r,
        input  erase_ready, addr_err, ram_req, ram_addr, ram_w, ram_w_en
    );

    // bet_update side
    modport slave (
        input  erase_valid, erase_addr, ram_gnt, ram_r,
        output erase_ready, addr_err, ram_req, ram_addr, ram_w, ram_w_en
    );
endinterface

// File: rtl/bet_update.sv
// BET flag read-modify-write on block erase, erase/flag counters and wear-level trigger.
// Latency: accept to BET write 4 cycles with grant held; back to ready after 5 (4 if already flagged).
// Backpressure: erase_ready low while an RMW or a pending BET clear is outstanding; RAM waits on ram_gnt.
module bet_update #(
    parameter int ADDR_W   = 12,
    parameter int BET_SIZE = 4096,
    parameter int CNT_W    = 32,
    parameter int T        = 100
) (
    input  logic             clk_50,
    input  logic             rst,
    bet_update_if.slave      bus,
    input  logic             bet_clr,
    output logic [CNT_W-1:0] e_cnt,
    output logic [CNT_W-1:0] f_cnt,
    output logic             wl_trigger
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD_WAIT,
        CHECK,
        WRITE
    } state_t;

    // One extra bit so an out-of-range index is representable in the compare.
    localparam logic [ADDR_W:0]    BET_LIM = (ADDR_W + 1)'(BET_SIZE);
    // Ratio product is kept 7 bits wider than the counters so T*f_cnt never wraps.
    localparam logic [CNT_W+6:0]   T_W     = (CNT_W + 7)'(T);

    state_t            state;
    state_t            state_nxt;
    logic              clr_pend;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              addr_bad;
    logic              start_rmw;
    logic              clr_now;
    logic [CNT_W+6:0]  thresh;

    // Ready is gated by rst so every output reads 0 while reset is held.
    assign bus.erase_ready = rst && (state == IDLE) && !clr_pend && !bet_clr;
    assign accept          = bus.erase_valid && bus.erase_ready;
    assign addr_bad        = {1'b0, bus.erase_addr} >= BET_LIM;
    assign start_rmw       = accept && !addr_bad;
    // Counter clears are deferred to IDLE so an RMW in flight is never split.
    assign clr_now         = (state == IDLE) && (clr_pend || bet_clr);
    assign bus.ram_w_en    = (state == WRITE);
    assign bus.ram_w       = (state == WRITE);
    assign thresh          = T_W * {7'b0, f_cnt};

    // State register
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode for the RMW sequence
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_rmw) state_nxt = REQ;
            REQ:     if (bus.ram_gnt) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = CHECK;
            CHECK:   state_nxt = bus.ram_r ? IDLE : WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address latch, RAM request/address and error pulse
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            bus.ram_addr <= '0;
            bus.ram_req  <= 1'b0;
            bus.addr_err <= 1'b0;
        end else begin
            bus.addr_err <= accept && addr_bad;
            if (accept) begin
                addr_q <= bus.erase_addr;
            end
            if ((state == REQ) && bus.ram_gnt) begin
                bus.ram_addr <= addr_q;
            end
            if (start_rmw) begin
                bus.ram_req <= 1'b1;
            end else if (((state == CHECK) && bus.ram_r) || (state == WRITE)) begin
                bus.ram_req <= 1'b0;
            end
        end
    end

    // Clear-pending latch: remembers a BET clear seen while busy
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            clr_pend <= 1'b0;
        end else if (clr_now) begin
            clr_pend <= 1'b0;
        end else if (bet_clr) begin
            clr_pend <= 1'b1;
        end
    end

    // Erase and flag counters; e_cnt saturates, f_cnt is bounded by the table size
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            e_cnt <= '0;
            f_cnt <= '0;
        end else if (clr_now) begin
            e_cnt <= '0;
            f_cnt <= '0;
        end else begin
            if (start_rmw && (e_cnt != '1)) begin
                e_cnt <= e_cnt + 1'b1;
            end
            if (state == WRITE) begin
                f_cnt <= f_cnt + 1'b1;
            end
        end
    end

    // Wear-level trigger from the registered counters, one cycle behind them
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            wl_trigger <= 1'b0;
        end else begin
            wl_trigger <= (f_cnt != '0) && ({7'b0, e_cnt} >= thresh);
        end
    end

endmodule

// File: tb/tb_bet_update.sv
// Directed bench for bet_update with a BET RAM model and an event scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_bet_update;

    localparam int AW = 13;

    typedef struct {
        bit            is_err;
        logic [AW-1:0] addr;
    } exp_t;

    logic        clk_50;
    logic        rst;
    logic        bet_clr;
    logic [31:0] e_cnt;
    logic [31:0] f_cnt;
    logic        wl_trigger;

    int   checks;
    int   errors;
    exp_t exp_q[$];
    bit   mem [8192];

    bet_update_if #(.ADDR_W(AW)) bus ();

    bet_update #(
        .ADDR_W  (AW),
        .BET_SIZE(4096),
        .CNT_W   (32),
        .T       (100)
    ) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .bus       (bus.slave),
        .bet_clr   (bet_clr),
        .e_cnt     (e_cnt),
        .f_cnt     (f_cnt),
        .wl_trigger(wl_trigger)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    // Synchronous 1-bit BET RAM: read data one cycle after the address
    always @(posedge clk_50) begin
        if (bus.ram_w_en) mem[bus.ram_addr] <= bus.ram_w;
        bus.ram_r <= mem[bus.ram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.erase_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.erase_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: erase_ready stayed 0 for %0d cycles", n);
        end
    endtask

    // Presents one erase; returns in the cycle after the accepting edge.
    task automatic erase(input logic [AW-1:0] a);
        wait_ready();
        bus.erase_valid = 1'b1;
        bus.erase_addr  = a;
        tick();
        bus.erase_valid = 1'b0;
    endtask

    // Monitor: every BET write or address error must match the next expected event
    always @(negedge clk_50) begin
        if (rst && (bus.ram_w_en || bus.addr_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: w_en=%0b err=%0b addr=%0h, none expected",
                         bus.ram_w_en, bus.addr_err, bus.ram_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("event_kind", {63'b0, bus.addr_err}, {63'b0, e.is_err});
                if (!e.is_err) begin
                    chk("write_addr", 64'(bus.ram_addr), 64'(e.addr));
                    chk("write_data", {63'b0, bus.ram_w}, 64'd1);
                end
            end
        end
    end

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b0;
        bet_clr         = 1'b0;
        bus.erase_valid = 1'b0;
        bus.erase_addr  = '0;
        bus.ram_gnt     = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_e_cnt", 64'(e_cnt), 0);
        chk("rst_f_cnt", 64'(f_cnt), 0);
        chk("rst_wl", {63'b0, wl_trigger}, 0);
        chk("rst_req", {63'b0, bus.ram_req}, 0);
        chk("rst_w_en", {63'b0, bus.ram_w_en}, 0);
        chk("rst_ready", {63'b0, bus.erase_ready}, 0);
        rst = 1'b1;
        tick();
        chk("ready_after_rst", {63'b0, bus.erase_ready}, 1);

        // 1: fresh block 5, write 4 cycles after accept
        exp_q.push_back('{1'b0, 13'd5});
        erase(13'd5);
        chk("t1_req", {63'b0, bus.ram_req}, 1);
        chk("t1_e_cnt", 64'(e_cnt), 1);
        chk("t1_busy", {63'b0, bus.erase_ready}, 0);
        tick(); tick(); tick();
        chk("t1_w_en", {63'b0, bus.ram_w_en}, 1);
        tick();
        chk("t1_ready", {63'b0, bus.erase_ready}, 1);
        chk("t1_f_cnt", 64'(f_cnt), 1);
        chk("t1_req_off", {63'b0, bus.ram_req}, 0);

        // 2: block 5 again, already flagged
        erase(13'd5);
        chk("t2_e_cnt", 64'(e_cnt), 2);
        tick(); tick();
        chk("t2_no_w_en", {63'b0, bus.ram_w_en}, 0);
        chk("t2_not_ready", {63'b0, bus.erase_ready}, 0);
        tick();
        chk("t2_ready", {63'b0, bus.erase_ready}, 1);
        chk("t2_f_cnt", 64'(f_cnt), 1);

        // 3: grant withheld for 3 cycles
        bus.ram_gnt = 1'b0;
        exp_q.push_back('{1'b0, 13'd7});
        erase(13'd7);
        for (int i = 0; i < 3; i++) begin
            chk("t3_req_held", {63'b0, bus.ram_req}, 1);
            chk("t3_busy", {63'b0, bus.erase_ready}, 0);
            chk("t3_no_w_en", {63'b0, bus.ram_w_en}, 0);
            tick();
        end
        bus.ram_gnt = 1'b1;
        tick(); tick(); tick();
        chk("t3_w_en", {63'b0, bus.ram_w_en}, 1);
        tick();
        chk("t3_ready", {63'b0, bus.erase_ready}, 1);
        chk("t3_f_cnt", 64'(f_cnt), 2);
        chk("t3_e_cnt", 64'(e_cnt), 3);

        // 5: clear pulse during RD_WAIT is deferred until the RMW completes
        exp_q.push_back('{1'b0, 13'd9});
        erase(13'd9);
        tick();
        bet_clr = 1'b1;
        tick();
        bet_clr = 1'b0;
        chk("t5_busy", {63'b0, bus.erase_ready}, 0);
        tick();
        chk("t5_w_en", {63'b0, bus.ram_w_en}, 1);
        tick();
        chk("t5_f_before_clr", 64'(f_cnt), 3);
        chk("t5_e_before_clr", 64'(e_cnt), 4);
        chk("t5_ready_clr_cycle", {63'b0, bus.erase_ready}, 0);
        tick();
        chk("t5_e_cleared", 64'(e_cnt), 0);
        chk("t5_f_cleared", 64'(f_cnt), 0);
        chk("t5_ready", {63'b0, bus.erase_ready}, 1);
        tick();
        chk("t5_wl", {63'b0, wl_trigger}, 0);

        // Clear and erase together in IDLE: clear wins
        bet_clr         = 1'b1;
        bus.erase_valid = 1'b1;
        bus.erase_addr  = 13'd11;
        #1;
        chk("clr_vs_erase_ready", {63'b0, bus.erase_ready}, 0);
        tick();
        bet_clr         = 1'b0;
        bus.erase_valid = 1'b0;
        chk("clr_vs_erase_e_cnt", 64'(e_cnt), 0);
        chk("clr_vs_erase_req", {63'b0, bus.ram_req}, 0);

        // 4: ratio threshold, one flag and 100 erases
        exp_q.push_back('{1'b0, 13'd11});
        erase(13'd11);
        for (int i = 0; i < 98; i++) erase(13'd11);
        wait_ready();
        chk("t4_e99", 64'(e_cnt), 99);
        chk("t4_f1", 64'(f_cnt), 1);
        tick();
        chk("t4_wl_99", {63'b0, wl_trigger}, 0);
        erase(13'd11);
        chk("t4_e100", 64'(e_cnt), 100);
        chk("t4_wl_lag", {63'b0, wl_trigger}, 0);
        tick();
        chk("t4_wl_100", {63'b0, wl_trigger}, 1);

        // 6: out-of-range address
        wait_ready();
        exp_q.push_back('{1'b1, 13'd0});
        erase(13'd4096);
        chk("t6_err", {63'b0, bus.addr_err}, 1);
        chk("t6_no_req", {63'b0, bus.ram_req}, 0);
        chk("t6_e_cnt", 64'(e_cnt), 100);
        tick();
        chk("t6_err_pulse", {63'b0, bus.addr_err}, 0);
        chk("t6_f_cnt", 64'(f_cnt), 1);

        // 6: reset asserted mid-WRITE
        erase(13'd13);
        chk("t6b_e_cnt", 64'(e_cnt), 101);
        tick(); tick(); tick();
        chk("t6b_w_en", {63'b0, bus.ram_w_en}, 1);
        chk("t6b_wl", {63'b0, wl_trigger}, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6b_w_en_rst", {63'b0, bus.ram_w_en}, 0);
        chk("t6b_w_rst", {63'b0, bus.ram_w}, 0);
        chk("t6b_req_rst", {63'b0, bus.ram_req}, 0);
        chk("t6b_addr_rst", 64'(bus.ram_addr), 0);
        chk("t6b_e_rst", 64'(e_cnt), 0);
        chk("t6b_f_rst", 64'(f_cnt), 0);
        chk("t6b_wl_rst", {63'b0, wl_trigger}, 0);
        chk("t6b_ready_rst", {63'b0, bus.erase_ready}, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_ready", {63'b0, bus.erase_ready}, 1);
        chk("queue_empty", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bet_update.md
Name: bet_update

Overview:
- Upstream stage of the wear-leveling BET scan FSM.
- Consumes block-erase notifications from the flash controller and does a read-modify-write of the 1-bit-per-block Block Erase Table (BET) RAM, setting the block's flag.
- Maintains the total erase counter (e_cnt) and the set-flag counter (f_cnt), and raises wl_trigger when e_cnt/f_cnt reaches the threshold.
- The scan FSM uses wl_trigger and f_cnt to decide when to start wear-leveling.

Parameters:
ADDR_W, 12, BET address width
BET_SIZE, 4096, number of blocks tracked; valid addresses are 0..BET_SIZE-1
CNT_W, 32, width of e_cnt and f_cnt
T, 100, erase/flag ratio threshold

Ports:
clk_50  input  1  clock
rst  input  1  asynchronous reset, active-low
erase_valid  input  1  erase notification valid
erase_addr  input  ADDR_W  erased block index
erase_ready  output  1  notification accepted when valid and ready are both high
addr_err  output  1  one-cycle pulse when an accepted erase_addr >= BET_SIZE
bet_clr  input  1  one-cycle pulse: BET was reset by the scan FSM; zero both counters
ram_req  output  1  request for the shared BET RAM port
ram_gnt  input  1  arbiter grant; stays high until ram_req drops
ram_addr  output  ADDR_W  BET RAM address
ram_w  output  1  BET write data
ram_w_en  output  1  BET write enable
ram_r  input  1  BET read data; synchronous RAM, valid 1 cycle after ram_addr
e_cnt  output  CNT_W  total accepted valid erases
f_cnt  output  CNT_W  number of BET flags set
wl_trigger  output  1  ratio threshold reached

Behaviour:
- Reset values: all outputs 0; state IDLE; clear-pending latch 0; internal latched address 0.
- erase_ready = (state==IDLE) and no clear pending and bet_clr low. Combinational from registered state.
- bet_clr is latched into clr_pend in any state. In IDLE, clr_pend (or bet_clr directly) zeroes e_cnt and f_cnt on that edge, then clears clr_pend. Clearing never happens mid-operation.
- States:
  - IDLE: on erase_valid & erase_ready, latch erase_addr.
    - If addr >= BET_SIZE: pulse addr_err next cycle, no counter change, stay IDLE.
    - Else: e_cnt += 1 (saturates at all-ones), ram_req <= 1, go REQ.
  - REQ: hold ram_req. When ram_gnt is high, drive ram_addr = latched addr, go RD_WAIT. Wait indefinitely without gnt. ram_addr is held at its last value until granted.
  - RD_WAIT: one cycle for RAM latency, then go CHECK.
  - CHECK: sample ram_r.
    - If 1 (already flagged): ram_req <= 0, go IDLE. No write, f_cnt unchanged.
    - If 0: go WRITE.
  - WRITE: ram_w_en=1, ram_w=1, ram_addr=latched addr for exactly one cycle. f_cnt += 1. ram_req <= 0, go IDLE.
- ram_w_en is never high outside WRITE. ram_w is 0 outside WRITE.
- Latency with ram_gnt already high:
  - accept at edge N, REQ N+1, RD_WAIT N+2, CHECK N+3, WRITE N+4, IDLE at N+5.
  - erase_ready high again in cycle N+5 (N+4 on the already-flagged path).
- f_cnt cannot exceed BET_SIZE in normal operation; it is not saturated.
- wl_trigger is registered and updated every cycle from the current registered counters (1-cycle lag): wl_trigger <= (f_cnt != 0) && (e_cnt >= T * f_cnt).
  - The product is computed at CNT_W+7 bits, with no truncation.
  - f_cnt == 0 forces wl_trigger to 0 (no divide-by-zero condition).
- Async reset in any state returns to the reset values immediately. An in-flight RMW is abandoned and ram_req drops asynchronously.
- Simultaneous bet_clr and erase_valid in IDLE: the clear wins, and the erase is not accepted that cycle (ready low).

Test Plan:
1. Reset, gnt=1, erase addr 5 with ram_r=0 -> ram_w_en/ram_w high at addr 5 exactly 4 cycles after accept. e_cnt=1, f_cnt=1, ready back at +5.
2. Repeat addr 5 with ram_r=1 -> no ram_w_en pulse, e_cnt=2, f_cnt=1, ready back at +4.
3. Hold ram_gnt low 3 cycles after accept -> ram_req high, erase_ready low, no write. Write occurs 3 cycles after gnt rises.
4. T=100: one flagged block, then erases to e_cnt=99 -> wl_trigger 0. After the 100th erase -> wl_trigger 1 one cycle after e_cnt=100.
5. Pulse bet_clr during RD_WAIT -> operation completes (f_cnt increments). Then counters go to 0 in IDLE, wl_trigger 0, erase_ready low during the clear cycle.
6. erase_addr=4096 -> addr_err one-cycle pulse, counters unchanged, no ram_req. Drop rst mid-WRITE -> all outputs 0 immediately.
